band_peak_buffer: RTL and testbench
===================================

# band_peak_buffer

Multi-channel, double-buffered band-magnitude store with peak-hold and linear decay. It sits between the FFT band-binning stage and the display/readout logic. It accepts per-channel frames of BANDS magnitudes over AXI-Stream and keeps one ping-pong bank pair per channel, so readers always see a complete, coherent frame. It also provides a synchronous random-access read port.

## Interface
- CHANNELS, 2, number of independent band streams (≥1)
- BANDS, 32, bands per frame (≥2)
- DATA_WIDTH, 16, magnitude width, unsigned
- DECAY_STEP, 300, amount subtracted per frame once hold expires
- HOLD_FRAMES, 8, frames a new peak is held before decay (used only with BPB_PEAK_HOLD_EN)
- clk_50m  in  1  system clock
- rst  in  1  asynchronous active-high reset
- peak_mode  in  1  1 = peak-hold/decay, 0 = pass-through (store latest)
- clear  in  1  pulse: start a full clear sweep
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  high when not clearing
- s_axis_tdata  in  DATA_WIDTH  band magnitude
- s_axis_tdest  in  max(1,$clog2(CHANNELS))  channel of this beat
- s_axis_tlast  in  1  last band of the channel's frame
- rd_ch  in  max(1,$clog2(CHANNELS))  read channel
- rd_addr  in  $clog2(BANDS)  read band
- rd_en  in  1  read request
- rd_data  out  DATA_WIDTH  registered read data
- rd_data_valid  out  1  rd_data valid this cycle
- frame_stb  out  1  one-cycle pulse: a channel swapped banks
- frame_ch  out  max(1,$clog2(CHANNELS))  channel of the last frame_stb
- frame_err  out  1  one-cycle pulse: frame length mismatch
- busy  out  1  clear sweep in progress

## Operation
- State machine with two states, CLEAR and RUN. Reset forces CLEAR with sweep counter 0.
- CLEAR: writes 0 to both banks and to the hold counter of entry (ch, band) = counter, one entry per cycle. Runs for CHANNELS*BANDS cycles, then moves to RUN. Also resets every per-channel write pointer and bank bit to 0. tready=0 and busy=1 throughout.
- RUN: tready=1. `clear` in RUN restarts the sweep on the next cycle. `clear` during CLEAR is ignored.
- Each channel has its own write pointer wp[ch] and bank bit wb[ch]. Writes go to bank wb[ch]. The display bank is !wb[ch]. Channels may interleave beat-by-beat.
- Accepted beat (tvalid&tready), with d = tdata and s = display[ch][wp]:
  - peak_mode=0: store d, and hold := 0.
  - peak_mode=1, d > s (unsigned): store d, and hold := HOLD_FRAMES.
  - peak_mode=1, d ≤ s, hold > 0: store s, and hold := hold − 1.
  - peak_mode=1, d ≤ s, hold = 0: store s − DECAY_STEP, saturating at 0.
- Frame end, when tlast=1: flip wb[ch], set wp[ch] := 0, pulse frame_stb, and set frame_ch := ch.
  - Early tlast (wp < BANDS−1) also pulses frame_err.
  - Write-bank entries not written this frame keep their stale contents.
- Overrun, when wp = BANDS−1 and tlast=0: write the beat, set wp := 0, pulse frame_err, and do not swap banks.
- Read: rd_en samples the display bank of rd_ch at rd_addr.
- Out-of-range rd_ch or tdest (≥ CHANNELS): reads return 0, and writes are dropped with a frame_err pulse.

## Timing
- Reset values: s_axis_tready=0, busy=1, frame_stb=0, frame_ch=0, frame_err=0, rd_data=0, rd_data_valid=0.
- Read latency is 1 cycle: rd_data_valid is high the cycle after rd_en. rd_data holds its value when rd_en=0.
- frame_stb and frame_err are asserted the cycle after the accepting beat.
- The bank swap is visible to reads issued the cycle after the tlast beat. A read in the same cycle as the tlast beat returns the old display bank.
- Reads during CLEAR are serviced. Their result is undefined until busy falls.
- Asserting rst mid-frame or mid-sweep restarts CLEAR from entry 0. A partial frame is discarded.

## Configuration
- BPB_PEAK_HOLD_EN defined: per-entry hold counters of width $clog2(HOLD_FRAMES+1) are implemented as described.
- BPB_PEAK_HOLD_EN undefined: no hold counters. In peak_mode=1, decay applies on every non-peak beat (HOLD_FRAMES is ignored).

## Test plan
- Reset released -> tready=0 and busy=1 for exactly CHANNELS*BANDS cycles (64 at defaults), then tready=1. Reading any entry then returns 0.
- peak_mode=0, ch0 frame tdata=band*10 with tlast on band 31 -> frame_stb=1 and frame_ch=0 one cycle later. Reading ch0 band 5 then returns 50, and ch1 band 5 returns 0.
- peak_mode=1, build/hold/decay sequence on ch1:
  - Frame of 1000s, then frames of 0s -> ch1 reads 1000 for frames 1..9.
  - With BPB_PEAK_HOLD_EN: after 8 hold frames, reads 700, then 400, then 100, then 0 (saturated).
- Interleaved ch0/ch1 beats -> each channel swaps only on its own tlast. Reads of the other channel stay unchanged.
- tlast at band 9 -> frame_err and frame_stb pulse, and the next frame starts at band 0. 33 beats without tlast -> frame_err at beat 32 with no swap.
- clear pulse mid-frame in RUN -> tready drops the next cycle for 64 cycles. All reads then return 0 and write pointers restart at 0.

Source files
------------

// File: rtl/band_peak_buffer.sv
// Multi-channel ping-pong band store with peak-hold/decay and a 1-cycle read port.
// Define BPB_PEAK_HOLD_EN to add per-entry hold counters before decay starts.
module band_peak_buffer #(
  parameter int CHANNELS    = 2,
  parameter int BANDS       = 32,
  parameter int DATA_WIDTH  = 16,
  parameter int DECAY_STEP  = 300,
  parameter int HOLD_FRAMES = 8,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int BAND_W     = $clog2(BANDS)
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  input  logic                  peak_mode,
  input  logic                  clear,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CH_W-1:0]       s_axis_tdest,
  input  logic                  s_axis_tlast,
  input  logic [CH_W-1:0]       rd_ch,
  input  logic [BAND_W-1:0]     rd_addr,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic                  frame_stb,
  output logic [CH_W-1:0]       frame_ch,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int ENTRIES = CHANNELS * BANDS;
  localparam int IDX_W   = $clog2(ENTRIES);
  localparam logic [DATA_WIDTH-1:0] DECAY     = DATA_WIDTH'(DECAY_STEP);
  localparam logic [BAND_W-1:0]     LAST_BAND = BAND_W'(BANDS - 1);
  localparam logic [CH_W-1:0]       LAST_CH   = CH_W'(CHANNELS - 1);

  if (CHANNELS < 1 || BANDS < 2 || HOLD_FRAMES < 1 || DECAY_STEP < 0) begin : g_param_check
    $error("band_peak_buffer: invalid parameter set");
  end

  typedef enum logic {CLEAR, RUN} state_t;
  state_t state;

  // Bank 0 and bank 1, flat-indexed by ch*BANDS+band.
  logic [DATA_WIDTH-1:0] mem0 [ENTRIES];
  logic [DATA_WIDTH-1:0] mem1 [ENTRIES];

`ifdef BPB_PEAK_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  logic [HOLD_W-1:0] hold_mem [ENTRIES];
  logic [HOLD_W-1:0] hold_cur;
  logic [HOLD_W-1:0] hold_new;
`endif

  logic [BAND_W-1:0] wp [CHANNELS];
  logic [CHANNELS-1:0] wb;
  logic [CH_W-1:0]   clr_ch;
  logic [BAND_W-1:0] clr_band;

  function automatic logic [IDX_W-1:0] entry_idx(input logic [CH_W-1:0] ch,
                                                 input logic [BAND_W-1:0] band);
    return IDX_W'(int'(ch) * BANDS + int'(band));
  endfunction

  logic                  accept;
  logic                  in_ok;
  logic                  in_wb;
  logic [CH_W-1:0]       in_ch;
  logic [BAND_W-1:0]     in_wp;
  logic [IDX_W-1:0]      in_idx;
  logic [DATA_WIDTH-1:0] s_val;
  logic [DATA_WIDTH-1:0] wr_val;
  logic                  beat_we;
  logic                  clearing;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_data;

  assign accept   = s_axis_tvalid & s_axis_tready;
  assign in_ok    = int'(s_axis_tdest) < CHANNELS;
  assign in_ch    = in_ok ? s_axis_tdest : '0;
  assign in_wp    = wp[in_ch];
  assign in_wb    = wb[in_ch];
  assign in_idx   = entry_idx(in_ch, in_wp);
  // Writes target bank wb; the display bank (!wb) supplies the previous value.
  assign s_val    = in_wb ? mem0[in_idx] : mem1[in_idx];
  assign clearing = (state == CLEAR);
  assign beat_we  = accept && (state == RUN) && !clear && in_ok;
  assign w_idx    = clearing ? entry_idx(clr_ch, clr_band) : in_idx;
  assign w_data   = clearing ? '0 : wr_val;

`ifdef BPB_PEAK_HOLD_EN
  assign hold_cur = hold_mem[in_idx];
`endif

  always_comb begin
    wr_val = s_axis_tdata;
`ifdef BPB_PEAK_HOLD_EN
    hold_new = '0;
    if (peak_mode) begin
      if (s_axis_tdata > s_val) begin
        hold_new = HOLD_W'(HOLD_FRAMES);
      end else if (hold_cur != '0) begin
        wr_val   = s_val;
        hold_new = hold_cur - 1'b1;
      end else begin
        wr_val = (s_val > DECAY) ? s_val - DECAY : '0;
      end
    end
`else
    if (peak_mode && s_axis_tdata <= s_val) begin
      wr_val = (s_val > DECAY) ? s_val - DECAY : '0;
    end
`endif
  end

  // Storage has no reset; the CLEAR sweep initialises it.
  always_ff @(posedge clk_50m) begin
    if (clearing || (beat_we && !in_wb)) mem0[w_idx] <= w_data;
    if (clearing || (beat_we && in_wb))  mem1[w_idx] <= w_data;
`ifdef BPB_PEAK_HOLD_EN
    if (clearing || beat_we) hold_mem[w_idx] <= clearing ? '0 : hold_new;
`endif
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state         <= CLEAR;
      clr_ch        <= '0;
      clr_band      <= '0;
      s_axis_tready <= 1'b0;
      busy          <= 1'b1;
      frame_stb     <= 1'b0;
      frame_ch      <= '0;
      frame_err     <= 1'b0;
      wb            <= '0;
      for (int i = 0; i < CHANNELS; i++) wp[i] <= '0;
    end else begin
      frame_stb <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        CLEAR: begin
          wb <= '0;
          for (int i = 0; i < CHANNELS; i++) wp[i] <= '0;
          if (clr_band == LAST_BAND) begin
            clr_band <= '0;
            if (clr_ch == LAST_CH) begin
              clr_ch        <= '0;
              state         <= RUN;
              s_axis_tready <= 1'b1;
              busy          <= 1'b0;
            end else begin
              clr_ch <= clr_ch + 1'b1;
            end
          end else begin
            clr_band <= clr_band + 1'b1;
          end
        end
        RUN: begin
          if (clear) begin
            state         <= CLEAR;
            clr_ch        <= '0;
            clr_band      <= '0;
            s_axis_tready <= 1'b0;
            busy          <= 1'b1;
          end else if (accept) begin
            if (!in_ok) begin
              frame_err <= 1'b1;
            end else if (s_axis_tlast) begin
              wb[in_ch] <= ~in_wb;
              wp[in_ch] <= '0;
              frame_stb <= 1'b1;
              frame_ch  <= in_ch;
              frame_err <= (in_wp != LAST_BAND);
            end else if (in_wp == LAST_BAND) begin
              // Overrun: wrap the pointer without publishing the frame.
              wp[in_ch] <= '0;
              frame_err <= 1'b1;
            end else begin
              wp[in_ch] <= in_wp + 1'b1;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  logic              rd_ok;
  logic [CH_W-1:0]   rd_ch_g;
  logic [BAND_W-1:0] rd_addr_g;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_wb;

  assign rd_ok     = (int'(rd_ch) < CHANNELS) && (int'(rd_addr) < BANDS);
  assign rd_ch_g   = rd_ok ? rd_ch : '0;
  assign rd_addr_g = rd_ok ? rd_addr : '0;
  assign rd_idx    = entry_idx(rd_ch_g, rd_addr_g);
  assign rd_wb     = wb[rd_ch_g];

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= rd_en;
      if (rd_en) begin
        if (!rd_ok)     rd_data <= '0;
        else if (rd_wb) rd_data <= mem0[rd_idx];
        else            rd_data <= mem1[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_band_peak_buffer.sv
// Directed bench for band_peak_buffer: sweep, pass-through, peak decay, interleave,
// frame errors and clear; expected values are hand-derived constants and a tiny decay model.
module tb_band_peak_buffer;
  localparam int CHANNELS = 2;
  localparam int BANDS    = 32;
  localparam int DW       = 16;

  logic          clk_50m = 1'b0;
  logic          rst = 1'b1;
  logic          peak_mode = 1'b0;
  logic          clear = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tdest = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          rd_ch = 1'b0;
  logic [4:0]    rd_addr = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          frame_stb;
  logic          frame_ch;
  logic          frame_err;
  logic          busy;

  int checks = 0;
  int errors = 0;

  band_peak_buffer #(
    .CHANNELS(CHANNELS), .BANDS(BANDS), .DATA_WIDTH(DW),
    .DECAY_STEP(300), .HOLD_FRAMES(8)
  ) dut (
    .clk_50m(clk_50m), .rst(rst), .peak_mode(peak_mode), .clear(clear),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tdest(s_axis_tdest),
    .s_axis_tlast(s_axis_tlast), .rd_ch(rd_ch), .rd_addr(rd_addr),
    .rd_en(rd_en), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .frame_stb(frame_stb), .frame_ch(frame_ch), .frame_err(frame_err),
    .busy(busy)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic beat(input int ch, input int d, input bit last);
    s_axis_tvalid = 1'b1;
    s_axis_tdest  = ch[0];
    s_axis_tdata  = d[DW-1:0];
    s_axis_tlast  = last;
    @(negedge clk_50m);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(input string tag, input int ch, input int base, input int step);
    for (int b = 0; b < BANDS; b++) beat(ch, base + b * step, b == BANDS - 1);
    $display("frame %s ch%0d base=%0d step=%0d", tag, ch, base, step);
    check({tag, "_stb"}, frame_stb, 1);
    check({tag, "_ch"}, frame_ch, ch);
    check({tag, "_err"}, frame_err, 0);
  endtask

  task automatic check_rd(input string tag, input int ch, input int addr, input int exp);
    rd_en   = 1'b1;
    rd_ch   = ch[0];
    rd_addr = addr[4:0];
    @(negedge clk_50m);
    rd_en = 1'b0;
    $display("read %s ch%0d band%0d -> %0d", tag, ch, addr, rd_data);
    check({tag, "_valid"}, rd_data_valid, 1);
    check(tag, rd_data, exp);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!s_axis_tready && n < 200) begin
      @(negedge clk_50m);
      n++;
    end
    $display("sweep %s took %0d cycles", tag, n);
    check({tag, "_cycles"}, n, CHANNELS * BANDS);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    int exp;

    repeat (3) @(negedge clk_50m);
    check("rst_tready", s_axis_tready, 0);
    check("rst_busy", busy, 1);
    check("rst_stb", frame_stb, 0);
    check("rst_frame_ch", frame_ch, 0);
    check("rst_err", frame_err, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_data_valid, 0);
    rst = 1'b0;
    wait_ready("reset_sweep");
    check_rd("init_ch0_b0", 0, 0, 0);
    check_rd("init_ch1_b31", 1, 31, 0);

    // Pass-through on ch0.
    peak_mode = 1'b0;
    send_frame("pass0", 0, 0, 10);
    check_rd("pass_ch1_b5", 1, 5, 0);
    check_rd("pass_ch0_b5", 0, 5, 50);
    check_rd("pass_ch0_b31", 0, 31, 310);
    @(negedge clk_50m);
    check("rd_hold_valid", rd_data_valid, 0);
    check("rd_hold_data", rd_data, 310);

    // Peak build, hold and decay on ch1.
    peak_mode = 1'b1;
    send_frame("peak1000", 1, 1000, 0);
    check_rd("peak_ch1_b3", 1, 3, 1000);
`ifdef BPB_PEAK_HOLD_EN
    hold = 8;
`else
    hold = 0;
`endif
    exp = 1000;
    for (int f = 0; f < 12; f++) begin
      send_frame("zero1", 1, 0, 0);
      if (hold > 0) hold--;
      else exp = (exp > 300) ? exp - 300 : 0;
      check_rd("decay_ch1_b3", 1, 3, exp);
    end
    check_rd("decay_ch0_untouched", 0, 5, 50);

    // Pass-through replaces a larger stored value.
    peak_mode = 1'b0;
    send_frame("ones0", 0, 1, 0);
    check_rd("ones_ch0_b5", 0, 5, 1);

    // Interleaved channels: ch0 completes, ch1 still mid-frame.
    for (int b = 0; b < BANDS; b++) begin
      beat(0, 500 + b, b == BANDS - 1);
      if (b == BANDS - 1) begin
        check("ilv_ch0_stb", frame_stb, 1);
        check("ilv_ch0_ch", frame_ch, 0);
        check("ilv_ch0_err", frame_err, 0);
      end else begin
        beat(1, 900 + b, 1'b0);
      end
    end
    check_rd("ilv_ch0_b2", 0, 2, 502);
    check_rd("ilv_ch1_b2_old", 1, 2, 0);
    // A read in the tlast cycle still sees the old display bank.
    rd_en = 1'b1; rd_ch = 1'b1; rd_addr = 5'd2;
    beat(1, 931, 1'b1);
    rd_en = 1'b0;
    check("same_cycle_read", rd_data, 0);
    check("ilv_ch1_stb", frame_stb, 1);
    check("ilv_ch1_ch", frame_ch, 1);
    check("ilv_ch1_err", frame_err, 0);
    check_rd("ilv_ch1_b2", 1, 2, 902);
    check_rd("ilv_ch1_b31", 1, 31, 931);
    check_rd("ilv_ch0_b2_kept", 0, 2, 502);

    // Early tlast at band 9.
    for (int b = 0; b < 10; b++) beat(0, 2000 + b, b == 9);
    check("early_err", frame_err, 1);
    check("early_stb", frame_stb, 1);
    check_rd("early_ch0_b5", 0, 5, 2005);
    check_rd("early_ch0_b20_stale", 0, 20, 1);
    send_frame("after_early", 0, 4000, 1);
    check_rd("after_early_b0", 0, 0, 4000);

    // Overrun: 33 beats without tlast.
    for (int b = 0; b < 33; b++) begin
      beat(0, 6000 + b, 1'b0);
      if (b == 31) begin
        check("ovr_err", frame_err, 1);
        check("ovr_stb", frame_stb, 0);
      end else if (b == 32) begin
        check("ovr_err_after", frame_err, 0);
      end
    end
    check_rd("ovr_no_swap", 0, 0, 4000);

    // Clear mid-frame.
    beat(1, 7, 1'b0);
    beat(1, 8, 1'b0);
    beat(1, 9, 1'b0);
    clear = 1'b1;
    @(negedge clk_50m);
    clear = 1'b0;
    check("clr_tready", s_axis_tready, 0);
    check("clr_busy", busy, 1);
    wait_ready("clear_sweep");
    check_rd("clr_ch0_b0", 0, 0, 0);
    check_rd("clr_ch1_b2", 1, 2, 0);
    check_rd("clr_ch1_b31", 1, 31, 0);
    send_frame("post_clear", 1, 100, 1);
    check_rd("post_clear_b0", 1, 0, 100);
    check_rd("post_clear_b31", 1, 31, 131);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
